// File: rtl/ufm_pkg.sv
// Shared definitions for the RAM-to-UFM write-back path: CSR addressing,
// status bit positions, control-word layout and the controller state set.
package ufm_pkg;

  localparam logic CSR_STATUS  = 1'b0;
  localparam logic CSR_CONTROL = 1'b1;

  localparam int unsigned ST_WRITE_OK = 3;
  localparam int unsigned ST_ERASE_OK = 4;

  localparam logic [2:0] ERASE_NONE = 3'b111;
  localparam logic [4:0] PROT_ALL   = 5'h1F;

  // Control word: [31:28]=F, [27:23]=protect mask, [22:20]=erase sector, [19:0]=F's
  function automatic logic [31:0] ctrl_word(input logic [4:0] mask, input logic [2:0] erase);
    return {4'hF, mask, erase, 20'hFFFFF};
  endfunction

  typedef enum logic [11:0] {
    S_IDLE   = 12'h001,
    S_UNPROT = 12'h002,
    S_ERASE  = 12'h004,
    S_EPOLL  = 12'h008,
    S_RDRAM  = 12'h010,
    S_RDWAIT = 12'h020,
    S_WR     = 12'h040,
    S_WPOLL  = 12'h080,
    S_PROT   = 12'h100,
    S_DONE   = 12'h200,
    S_FPROT  = 12'h400,
    S_FAIL   = 12'h800
  } state_e;

endpackage

// File: rtl/ufm_ram_write_back_if.sv
// RAM read port, UFM data port and UFM CSR port seen by the write-back engine.
interface ufm_ram_write_back_if #(
  parameter int unsigned num_addr_bits = 9
);
  logic [num_addr_bits-1:0] ram_addr_o;
  logic                     ram_read_enable_o;
  logic [31:0]              ram_data_i;
  logic [31:0]              ufm_data_o;
  logic [num_addr_bits-1:0] ufm_addr_o;
  logic                     ufm_write_o;
  logic [1:0]               ufm_burst_count_o;
  logic                     ufm_wait_req_i;
  logic                     csr_addr_o;
  logic                     csr_read_o;
  logic                     csr_write_o;
  logic [31:0]              csr_writedata_o;
  logic [31:0]              csr_readdata_i;

  modport master (
    output ram_addr_o, ram_read_enable_o, ufm_data_o, ufm_addr_o, ufm_write_o,
           ufm_burst_count_o, csr_addr_o, csr_read_o, csr_write_o, csr_writedata_o,
    input  ram_data_i, ufm_wait_req_i, csr_readdata_i
  );

  modport slave (
    input  ram_addr_o, ram_read_enable_o, ufm_data_o, ufm_addr_o, ufm_write_o,
           ufm_burst_count_o, csr_addr_o, csr_read_o, csr_write_o, csr_writedata_o,
    output ram_data_i, ufm_wait_req_i, csr_readdata_i
  );
endinterface

// File: rtl/ufm_csr_poll.sv
// Status poller: alternates a status read with an evaluation cycle until the
// flash reports not-busy, then pulses done_o with the selected ok bit.
module ufm_csr_poll
  import ufm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        active_i,
  input  logic        ok_sel_i,    // 0 = erase-ok, 1 = write-ok
  input  logic [31:0] readdata_i,
  output logic        read_o,
  output logic        done_o,
  output logic        ok_o
);
  logic phase_q, phase_d;
  logic unused_bits;

  assign unused_bits = ^{readdata_i[31:5], readdata_i[2]};

  // Phase register: 0 = issue read, 1 = evaluate returned status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= 1'b0;
    else          phase_q <= phase_d;
  end

  // Read strobe and completion decode
  always_comb begin
    phase_d = 1'b0;
    read_o  = 1'b0;
    done_o  = 1'b0;
    ok_o    = 1'b0;
    if (active_i) begin
      if (!phase_q) begin
        read_o  = 1'b1;
        phase_d = 1'b1;
      end else if (readdata_i[1:0] == 2'b00) begin
        done_o = 1'b1;
        ok_o   = ok_sel_i ? readdata_i[ST_WRITE_OK] : readdata_i[ST_ERASE_OK];
      end
    end
  end
endmodule

// File: rtl/ufm_ram_write_back.sv
// Copies num_words RAM words into one UFM sector: unprotect, erase, stream
// single-beat writes with status polling, then re-protect (also on failure).
module ufm_ram_write_back
  import ufm_pkg::*;
#(
  parameter int unsigned num_words = 512,
  parameter int unsigned sector    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  ufm_ram_write_back_if.master bus,
  output logic                 busy,
  output logic                 complete,
  output logic                 error
);
  localparam int unsigned num_addr_bits = $clog2(num_words);
  localparam logic [num_addr_bits-1:0] LAST = num_addr_bits'(num_words - 1);
  localparam logic [4:0]  UNPROT_MASK = PROT_ALL & ~(5'(1) << (sector - 1));
  localparam logic [31:0] W_UNPROT = ctrl_word(UNPROT_MASK, ERASE_NONE);
  localparam logic [31:0] W_ERASE  = ctrl_word(UNPROT_MASK, 3'(sector));
  localparam logic [31:0] W_PROT   = ctrl_word(PROT_ALL, ERASE_NONE);

  state_e                   state_q, state_d;
  logic [num_addr_bits-1:0] wc_q, wc_d;
  logic [31:0]              data_q, data_d;
  logic                     poll_active, poll_sel, poll_read, poll_done, poll_ok;

  ufm_csr_poll u_poll (
    .clk        (clk),
    .reset_n    (reset_n),
    .active_i   (poll_active),
    .ok_sel_i   (poll_sel),
    .readdata_i (bus.csr_readdata_i),
    .read_o     (poll_read),
    .done_o     (poll_done),
    .ok_o       (poll_ok)
  );

  assign bus.ram_addr_o        = wc_q;
  assign bus.ufm_addr_o        = wc_q;
  assign bus.ufm_data_o        = data_q;
  assign bus.ufm_burst_count_o = 2'd1;
  assign bus.csr_read_o        = poll_read;

  // State, word counter and write-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wc_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      data_q  <= data_d;
    end
  end

  // Next-state and bus strobes
  always_comb begin
    state_d               = state_q;
    wc_d                  = wc_q;
    data_d                = data_q;
    poll_active           = 1'b0;
    poll_sel              = 1'b0;
    bus.ram_read_enable_o = 1'b0;
    bus.ufm_write_o       = 1'b0;
    bus.csr_addr_o        = CSR_STATUS;
    bus.csr_write_o       = 1'b0;
    bus.csr_writedata_o   = '0;
    busy                  = 1'b1;
    complete              = 1'b0;
    error                 = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        busy     = 1'b0;
        complete = (state_q == S_DONE);
        error    = (state_q == S_FAIL);
        if (start) begin
          wc_d    = '0;
          state_d = S_UNPROT;
        end
      end
      S_UNPROT: begin
        bus.csr_write_o     = 1'b1;
        bus.csr_addr_o      = CSR_CONTROL;
        bus.csr_writedata_o = W_UNPROT;
        state_d             = S_ERASE;
      end
      S_ERASE: begin
        bus.csr_write_o     = 1'b1;
        bus.csr_addr_o      = CSR_CONTROL;
        bus.csr_writedata_o = W_ERASE;
        state_d             = S_EPOLL;
      end
      S_EPOLL: begin
        poll_active = 1'b1;
        if (poll_done) state_d = poll_ok ? S_RDRAM : S_FPROT;
      end
      S_RDRAM: begin
        bus.ram_read_enable_o = 1'b1;
        state_d               = S_RDWAIT;
      end
      S_RDWAIT: begin
        data_d  = bus.ram_data_i;
        state_d = S_WR;
      end
      S_WR: begin
        bus.ufm_write_o = 1'b1;
        if (!bus.ufm_wait_req_i) state_d = S_WPOLL;
      end
      S_WPOLL: begin
        poll_active = 1'b1;
        poll_sel    = 1'b1;
        if (poll_done) begin
          if (!poll_ok)          state_d = S_FPROT;
          else if (wc_q == LAST) state_d = S_PROT;
          else begin
            wc_d    = wc_q + num_addr_bits'(1);
            state_d = S_RDRAM;
          end
        end
      end
      S_PROT, S_FPROT: begin
        bus.csr_write_o     = 1'b1;
        bus.csr_addr_o      = CSR_CONTROL;
        bus.csr_writedata_o = W_PROT;
        state_d             = (state_q == S_PROT) ? S_DONE : S_FAIL;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ufm_ram_write_back.sv
// Scoreboard bench for ufm_ram_write_back: 4 words into sector 1 against a
// flash model that reports busy for 3 status reads after each operation.
module tb_ufm_ram_write_back;
  localparam int unsigned NW = 4;
  localparam int unsigned AW = 2;

  // Sector 1: unprotect mask 5'h1E, erase field 1, protect mask 5'h1F
  localparam logic [31:0] W_UNPROT = 32'hFF7F_FFFF;
  localparam logic [31:0] W_ERASE  = 32'hFF1F_FFFF;
  localparam logic [31:0] W_PROT   = 32'hFFFF_FFFF;

  typedef struct {
    logic        is_csr;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, complete, error;

  ufm_ram_write_back_if #(.num_addr_bits(AW)) bus ();

  ufm_ram_write_back #(.num_words(NW), .sector(1)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .complete (complete),
    .error    (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  ev_t exp_q[$];
  logic [31:0] ram [NW] = '{32'h1111_00A0, 32'h2222_00A1, 32'h3333_00A2, 32'h4444_00A3};

  // flash model controls
  int busy_polls = 3;
  logic erase_ok = 1'b1;
  int bad_word = -1;
  int wait_word = -1;
  int wait_left = 0;
  int busy_left = 0;
  int wr_count = 0;
  int stall_cnt = 0;
  logic [31:0] status = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic is_csr, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.is_csr = is_csr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_full_run();
    push_ev(1'b1, 32'd1, W_UNPROT);
    push_ev(1'b1, 32'd1, W_ERASE);
    for (int i = 0; i < NW; i++) push_ev(1'b0, 32'(i), ram[i]);
    push_ev(1'b1, 32'd1, W_PROT);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!(complete || error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n < 3000), 32'd1);
    @(negedge clk);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Flash and RAM model: responds just after each rising edge
  initial begin
    bus.ram_data_i = '0;
    bus.ufm_wait_req_i = 1'b0;
    bus.csr_readdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        busy_left = 0;
        bus.ufm_wait_req_i = 1'b0;
        continue;
      end
      if (bus.ram_read_enable_o) bus.ram_data_i = ram[bus.ram_addr_o];
      if (bus.csr_write_o && bus.csr_addr_o) begin
        if (bus.csr_writedata_o[22:20] != 3'b111) begin
          busy_left = busy_polls;
          status = erase_ok ? 32'h10 : 32'h0;
        end else if (!bus.csr_writedata_o[23]) begin
          wr_count = 0;
        end
      end
      if (bus.csr_read_o) begin
        if (busy_left > 0) begin
          bus.csr_readdata_i = 32'h1;
          busy_left--;
        end else begin
          bus.csr_readdata_i = status;
        end
      end
      if (bus.ufm_write_o && wr_count == wait_word && wait_left > 0) begin
        bus.ufm_wait_req_i = 1'b1;
        wait_left--;
      end else begin
        bus.ufm_wait_req_i = 1'b0;
        if (bus.ufm_write_o) begin
          status = (wr_count == bad_word) ? 32'h0 : 32'h8;
          busy_left = busy_polls;
          wr_count++;
        end
      end
    end
  end

  task automatic check_ev(input logic is_csr, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_xfer actual=csr:%0b addr=%h data=%h required=none", is_csr, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.is_csr !== is_csr || e.addr !== addr || e.data !== data) begin
        bad++;
        $display("FAIL xfer actual=csr:%0b addr=%h data=%h required=csr:%0b addr=%h data=%h",
                 is_csr, addr, data, e.is_csr, e.addr, e.data);
      end
    end
  endtask

  // Monitor: compares each bus transfer against the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      if (bus.csr_read_o || bus.csr_write_o)
        check("csr_strobe_excl", 32'(bus.csr_read_o & bus.csr_write_o), 32'd0);
      if (bus.csr_write_o) check_ev(1'b1, 32'(bus.csr_addr_o), bus.csr_writedata_o);
      if (bus.ufm_write_o) begin
        if (bus.ufm_wait_req_i) begin
          stall_cnt++;
          if (exp_q.size() == 0) check("stall_no_expect", 32'd1, 32'd0);
          else begin
            check("stall_addr", 32'(bus.ufm_addr_o), exp_q[0].addr);
            check("stall_data", bus.ufm_data_o, exp_q[0].data);
          end
        end else begin
          check_ev(1'b0, 32'(bus.ufm_addr_o), bus.ufm_data_o);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_complete"}, 32'(complete), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
    check({name, "_strobes"}, 32'({bus.csr_read_o, bus.csr_write_o, bus.ufm_write_o, bus.ram_read_enable_o}), 32'd0);
    check({name, "_ufm_data"}, bus.ufm_data_o, 32'd0);
    check({name, "_csr_wdata"}, bus.csr_writedata_o, 32'd0);
    check({name, "_addrs"}, 32'({bus.ufm_addr_o, bus.ram_addr_o, bus.csr_addr_o}), 32'd0);
    check({name, "_burst"}, 32'(bus.ufm_burst_count_o), 32'd1);
  endtask

  // Stimulus
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Normal run with a stray start while busy
    push_full_run();
    pulse_start();
    repeat (10) @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    pulse_start();
    wait_end("run1");
    check("run1_complete", 32'(complete), 32'd1);
    check("run1_error", 32'(error), 32'd0);
    check("run1_busy", 32'(busy), 32'd0);

    // Second run from DONE, word 2 stalled for 5 cycles
    stall_cnt = 0;
    wait_word = 2;
    wait_left = 5;
    push_full_run();
    pulse_start();
    wait_end("run2");
    check("run2_complete", 32'(complete), 32'd1);
    check("run2_stall_cycles", 32'(stall_cnt), 32'd5);
    wait_word = -1;

    // Erase reports failure
    erase_ok = 1'b0;
    push_ev(1'b1, 32'd1, W_UNPROT);
    push_ev(1'b1, 32'd1, W_ERASE);
    push_ev(1'b1, 32'd1, W_PROT);
    pulse_start();
    wait_end("erase_fail");
    check("erase_fail_error", 32'(error), 32'd1);
    check("erase_fail_complete", 32'(complete), 32'd0);
    erase_ok = 1'b1;

    // Write-ok low on word 1
    bad_word = 1;
    push_ev(1'b1, 32'd1, W_UNPROT);
    push_ev(1'b1, 32'd1, W_ERASE);
    push_ev(1'b0, 32'd0, ram[0]);
    push_ev(1'b0, 32'd1, ram[1]);
    push_ev(1'b1, 32'd1, W_PROT);
    pulse_start();
    wait_end("write_fail");
    check("write_fail_error", 32'(error), 32'd1);
    bad_word = -1;

    // Reset while word 1 is stalled in WR
    wait_word = 1;
    wait_left = 50;
    push_ev(1'b1, 32'd1, W_UNPROT);
    push_ev(1'b1, 32'd1, W_ERASE);
    push_ev(1'b0, 32'd0, ram[0]);
    push_ev(1'b0, 32'd1, ram[1]);
    pulse_start();
    n = 0;
    while (!(bus.ufm_write_o && bus.ufm_addr_o == AW'(1)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("reach_wr1", 32'(n < 3000), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("async_reset");
    exp_q.delete();
    wait_left = 0;
    wait_word = -1;
    @(negedge clk);
    reset_n = 1'b1;

    // Fresh run after the abort starts again at word 0
    push_full_run();
    pulse_start();
    wait_end("run3");
    check("run3_complete", 32'(complete), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
